// File: rtl/fetch_stage.sv
// Instruction fetch stage: registered fetch PC, next-PC select resolved in D, and the IF/ID register.
// Defining FETCH_STAT_EN adds the fetch_cnt / stall_cnt statistics counters.
module fetch_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [2:0]  npc_op,
  input  logic        cmp_eq,
  input  logic [31:0] jr_target,
  input  logic [31:0] im_instr,
  output logic [31:0] f_pc,
  output logic [31:0] d_instr,
  output logic [31:0] d_pc,
  output logic [31:0] d_pc8
`ifdef FETCH_STAT_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] stall_cnt
`endif
);

  localparam logic [2:0] NPC_BEQ = 3'b001;
  localparam logic [2:0] NPC_JAL = 3'b010;
  localparam logic [2:0] NPC_JR  = 3'b011;
  localparam logic [2:0] NPC_J   = 3'b100;

  logic [31:0] f_pc_q, f_pc_d;
  logic [31:0] d_instr_q, d_instr_d;
  logic [31:0] d_pc_q, d_pc_d;
  logic [31:0] d_pc_plus4;
  logic [31:0] br_offset;
  logic [31:0] next_pc;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    d_pc_plus4 = d_pc_q + 32'd4;
    br_offset  = {{14{d_instr_q[15]}}, d_instr_q[15:0], 2'b00};
    next_pc    = f_pc_q + 32'd4;
    case (npc_op)
      NPC_BEQ: if (cmp_eq) next_pc = d_pc_plus4 + br_offset;
      NPC_JAL,
      NPC_J:   next_pc = {d_pc_plus4[31:28], d_instr_q[25:0], 2'b00};
      NPC_JR:  next_pc = jr_target;
      default: ;
    endcase
  end

  // A stall freezes PC and IF/ID; the redirect is simply re-evaluated once it drops.
  always_comb begin
    f_pc_d    = f_pc_q;
    d_instr_d = d_instr_q;
    d_pc_d    = d_pc_q;
    if (!stall) begin
      f_pc_d    = next_pc;
      d_instr_d = im_instr;
      d_pc_d    = f_pc_q;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      f_pc_q    <= PC_RESET;
      d_instr_q <= 32'h0;
      d_pc_q    <= 32'h0;
    end else begin
      f_pc_q    <= f_pc_d;
      d_instr_q <= d_instr_d;
      d_pc_q    <= d_pc_d;
    end
  end

  assign f_pc    = f_pc_q;
  assign d_instr = d_instr_q;
  assign d_pc    = d_pc_q;
  assign d_pc8   = d_pc_q + 32'd8;

`ifdef FETCH_STAT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (stall) stall_cnt_d = stall_cnt_q + 32'd1;
    else       fetch_cnt_d = fetch_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt_q <= 32'h0;
      stall_cnt_q <= 32'h0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fetch_cnt = fetch_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter PC_RESET, default 32'h0000_3000, meaning the PC value loaded on reset.
REQ-002 SHALL use one clock and a synchronous, active-high reset.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port reset  input  1  synchronous active-high reset.
REQ-005 SHALL have port stall  input  1  hazard-unit hold of PC and IF/ID register.
REQ-006 SHALL have port npc_op  input  3  next-PC select decoded from d_instr: 000 seq, 001 beq, 010 jal, 011 jr, 100 j.
REQ-007 SHALL have port cmp_eq  input  1  D-stage rs==rt compare result (forwarded operands).
REQ-008 SHALL have port jr_target  input  32  forwarded rs value for jr.
REQ-009 SHALL have port im_instr  input  32  instruction memory data at f_pc, combinational.
REQ-010 SHALL have port f_pc  output  32  fetch PC driving the instruction memory address.
REQ-011 SHALL have port d_instr  output  32  IF/ID instruction.
REQ-012 SHALL have port d_pc  output  32  IF/ID PC of d_instr.
REQ-013 SHALL have port d_pc8  output  32  d_pc+8, the jal link value.

Function
REQ-014 SHALL register f_pc; each non-stalled clock loads next_pc.
REQ-015 SHALL compute next_pc combinationally from D-stage state:
- npc_op=001 and cmp_eq=1: d_pc+4+(sext(d_instr[15:0])<<2).
- npc_op=010 or 100: {d_pc_plus4[31:28], d_instr[25:0], 2'b00}.
- npc_op=011: jr_target.
- All other cases, including beq with cmp_eq=0 and codes 101-111: f_pc+4.
REQ-016 SHALL implement one branch delay slot: the instruction fetched in the cycle the branch sits in D always enters IF/ID. There is no flush.
REQ-017 SHALL load d_instr<=im_instr and d_pc<=f_pc on each non-stalled clock, giving 1-cycle IF->ID latency.
REQ-018 SHALL drive d_pc8 combinationally as d_pc+8, using 32-bit modulo arithmetic.
REQ-019 SHALL hold f_pc, d_instr and d_pc unchanged while stall=1; the redirect is re-evaluated when stall deasserts.
REQ-020 SHALL ignore npc_op, cmp_eq and jr_target while stall=1.
REQ-021 SHALL wrap all PC adders modulo 2^32; f_pc=32'hFFFF_FFFC advances to 32'h0000_0000.
REQ-022 SHALL perform no alignment check; jr_target is passed through unchanged.

Reset
REQ-023 SHALL, on reset=1 at a clock edge, set f_pc=PC_RESET, d_instr=32'h0 (nop) and d_pc=32'h0.
REQ-024 SHALL give reset priority over stall and over any redirect, including reset asserted mid-stall.
REQ-025 SHALL, in the first cycle after reset deasserts, fetch from PC_RESET with d_instr=nop.

Configuration
REQ-026 SHALL, with macro FETCH_STAT_EN defined, add output ports fetch_cnt (32) and stall_cnt (32).
- fetch_cnt increments on each non-stalled, non-reset clock.
- stall_cnt increments on each stall=1, non-reset clock.
- Both counters clear to 0 on reset and wrap at 2^32.
REQ-027 SHALL, without FETCH_STAT_EN, have neither port nor any counter logic, and SHALL be otherwise identical.

Verification
REQ-028 SHALL cover reset: reset=1 for 2 clocks -> f_pc=0x3000, d_instr=0, d_pc=0, d_pc8=0x8; counters (if enabled) =0.
REQ-029 SHALL cover sequential fetch: im_instr=0x34010001 at f_pc=0x3000, one clock -> d_instr=0x34010001, d_pc=0x3000, d_pc8=0x3008, f_pc=0x3004.
REQ-030 SHALL cover taken branch: d_instr=0x1000FFFF, d_pc=0x3008, npc_op=001, cmp_eq=1 -> f_pc becomes 0x3008 and the delay slot from 0x300C enters D; with cmp_eq=0 -> f_pc=0x3010.
REQ-031 SHALL cover jal and jr:
- d_instr=0x0C000C10, d_pc=0x3000, npc_op=010 -> f_pc=0x3040, d_pc8=0x3008.
- npc_op=011, jr_target=0x3100 -> f_pc=0x3100.
REQ-032 SHALL cover stall: stall=1 for 3 clocks with npc_op=100 -> f_pc and d_* unchanged, stall_cnt+=3; after release the j target is taken.
REQ-033 SHALL cover reset during stall: stall=1 with reset=1 -> REQ-023 values next clock.
